// File: rtl/spi_slave_byte.sv
// SPI responder byte engine (mode 3, MSB first).
//
// Oversamples spi_clk, cs and mosi in the clk domain. Received bits are
// assembled into rx_data. A preloaded response byte is shifted out on miso.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   spi_clk, cs, mosi SPI bus inputs from the master (cs active-low)
//   miso, miso_oe     SPI data out and its pad output enable
//   tx_data/tx_valid  response byte into the holding register
//   tx_ready          holding register empty
//   rx_data/rx_valid  last received byte, one-cycle valid pulse
//   busy              frame active
//   underrun          pulse: a byte was started with an empty holding register
//   abort             pulse: cs rose in the middle of a byte
module spi_slave_byte #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_MISO   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun,
    output logic              abort
);

    localparam int unsigned       CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_ACTIVE = 1'b1;
    localparam logic [DATA_W-1:0] IDLE_WORD = {DATA_W{IDLE_MISO}};

    // Synchronisers and edge-history flops
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_hist, cs_hist;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    // cs resets low so a frame already running at reset release is skipped
    // until cs has been seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '1;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_hist <= 1'b1;
            cs_hist   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_hist <= sclk_s;
            cs_hist   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_rise   = cs_s & ~cs_hist;
    assign cs_fall   = ~cs_s & cs_hist;

    // Byte engine state
    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              done_q, done_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              abort_q, abort_d;
    logic              reload;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        reload      = 1'b0;

        // A capture coinciding with a reload is not visible to that reload:
        // the reload below looks at hold_full_q.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        // Byte completed on the previous cycle's rising edge
        if (done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    reload  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // cs rising edge takes priority over any spi_clk edge
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = IDLE_MISO;
                    if (cnt_q != '0) begin
                        abort_d = 1'b1;
                    end
                end else begin
                    if (done_q) begin
                        reload = 1'b1;
                    end
                    if (sclk_fall) begin
                        miso_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], IDLE_MISO};
                    end
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reload) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_shift_q  <= IDLE_WORD;
            tx_shift_q  <= IDLE_WORD;
            hold_q      <= IDLE_WORD;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
            miso_q      <= IDLE_MISO;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            done_q      <= done_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = (state_q == ST_ACTIVE);
    assign busy     = (state_q == ST_ACTIVE);
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: a bus master drives mode-3 frames at clk/8 and
// checks each MISO bit it samples. A transaction-level model schedules the
// expected pulses and level changes by cycle number, and one compare process
// checks every DUT output on every negative clock edge.
module tb_spi_slave_byte;

    localparam int unsigned DW   = 8;
    localparam int          S    = 2;
    localparam logic        IDLE = 1'b1;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          spi_clk  = 1'b1;
    logic          cs       = 1'b1;
    logic          mosi     = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          miso, miso_oe, tx_ready, rx_valid, busy, underrun, abort;
    logic [DW-1:0] rx_data;

    spi_slave_byte #(
        .DATA_W     (DW),
        .SYNC_STAGES(S),
        .IDLE_MISO  (IDLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .spi_clk (spi_clk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .underrun(underrun),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: holding register, expected levels, and cycle-stamped events
    bit         m_full       = 1'b0;
    logic [7:0] m_hold       = '0;
    bit         cs_seen_high = 1'b0;
    logic       exp_busy     = 1'b0;
    logic       exp_rdy      = 1'b1;
    logic [7:0] exp_rx       = '0;
    int         rxv_c[$];
    logic [7:0] rxv_d[$];
    int         und_c[$];
    int         abt_c[$];
    int         bsy_c[$];
    bit         bsy_v[$];
    int         rdy_c[$];
    bit         rdy_v[$];
    int         rxv_cnt      = 0;
    int         und_cnt      = 0;
    int         abt_cnt      = 0;
    int         last_rxv_cyc = 0;

    always @(negedge clk) begin
        bit e_rxv, e_und, e_abt;
        e_rxv = 1'b0;
        e_und = 1'b0;
        e_abt = 1'b0;
        while (bsy_c.size() > 0 && bsy_c[0] <= cyc) begin
            exp_busy = bsy_v[0];
            bsy_c.delete(0);
            bsy_v.delete(0);
        end
        while (rdy_c.size() > 0 && rdy_c[0] <= cyc) begin
            exp_rdy = rdy_v[0];
            rdy_c.delete(0);
            rdy_v.delete(0);
        end
        while (rxv_c.size() > 0 && rxv_c[0] <= cyc) begin
            if (rxv_c[0] == cyc) begin
                e_rxv  = 1'b1;
                exp_rx = rxv_d[0];
            end
            rxv_c.delete(0);
            rxv_d.delete(0);
        end
        while (und_c.size() > 0 && und_c[0] <= cyc) begin
            if (und_c[0] == cyc) e_und = 1'b1;
            und_c.delete(0);
        end
        while (abt_c.size() > 0 && abt_c[0] <= cyc) begin
            if (abt_c[0] == cyc) e_abt = 1'b1;
            abt_c.delete(0);
        end
        if (rx_valid) begin
            rxv_cnt++;
            last_rxv_cyc = cyc;
        end
        if (underrun) und_cnt++;
        if (abort) abt_cnt++;
        chk(rx_valid == e_rxv, "rx_valid", rx_valid, e_rxv);
        chk(rx_data == exp_rx, "rx_data", rx_data, exp_rx);
        chk(underrun == e_und, "underrun", underrun, e_und);
        chk(abort == e_abt, "abort", abort, e_abt);
        chk(busy == exp_busy, "busy", busy, exp_busy);
        chk(miso_oe == exp_busy, "miso_oe", miso_oe, exp_busy);
        chk(tx_ready == exp_rdy, "tx_ready", tx_ready, exp_rdy);
        if (!exp_busy) chk(miso == IDLE, "miso_idle", miso, IDLE);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_load(input logic [7:0] v, input int eff);
        if (!m_full) begin
            m_hold = v;
            m_full = 1'b1;
            rdy_c.push_back(eff);
            rdy_v.push_back(1'b0);
        end
    endtask

    // Start of a byte: takes the holding register, or fills and flags underrun
    task automatic model_reload(input int eff, output logic [7:0] out);
        if (m_full) begin
            out    = m_hold;
            m_full = 1'b0;
            rdy_c.push_back(eff);
            rdy_v.push_back(1'b1);
        end else begin
            out = {8{IDLE}};
            und_c.push_back(eff);
        end
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_valid = 1'b1;
        tx_data  = v;
        model_load(v, cyc + 1);
        step();
        tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxv_c.delete();
        rxv_d.delete();
        und_c.delete();
        abt_c.delete();
        bsy_c.delete();
        bsy_v.delete();
        rdy_c.delete();
        rdy_v.delete();
        m_full       = 1'b0;
        exp_busy     = 1'b0;
        exp_rdy      = 1'b1;
        exp_rx       = '0;
        cs_seen_high = 1'b0;
        repeat (3) step();
        rst          = 1'b0;
        cs_seen_high = cs;
    endtask

    // One cs-low frame of nbits mode-3 clocks (half period 4 clk).
    // load_bit: tx load right after that bit's rising edge (-1 none).
    // coinc_byte: tx load on the same cycle as the reload after that byte.
    // rst_bit: reset pulse after that bit; the rest of the frame is ignored.
    task automatic frame(input int nbits, input logic [31:0] mvec, input int load_bit,
                         input int coinc_byte, input logic [7:0] load_val, input int rst_bit,
                         output logic [31:0] miso_cap, output int last_rise);
        logic [7:0] txb, rxa;
        bit         live;
        int         c;
        logic       exp_bit;
        miso_cap  = '0;
        rxa       = '0;
        last_rise = 0;
        txb       = {8{IDLE}};
        repeat (6) step();
        live = cs_seen_high;
        cs   = 1'b0;
        c    = cyc;
        if (live) begin
            bsy_c.push_back(c + S + 1);
            bsy_v.push_back(1'b1);
            model_reload(c + S + 1, txb);
        end
        repeat (4) step();
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            mosi    = mvec[nbits-1-i];
            repeat (4) step();
            exp_bit  = live ? txb[7-(i%8)] : IDLE;
            miso_cap = {miso_cap[30:0], miso};
            chk(miso == exp_bit, "miso_bit", miso, exp_bit);
            spi_clk   = 1'b1;
            c         = cyc;
            last_rise = c;
            rxa       = {rxa[6:0], mosi};
            for (int j = 0; j < 4; j++) begin
                if (live && (i % 8) == 7 && j == S + 1) begin
                    rxv_c.push_back(c + S + 2);
                    rxv_d.push_back(rxa);
                    model_reload(c + S + 2, txb);
                    if (i / 8 == coinc_byte) begin
                        tx_valid = 1'b1;
                        tx_data  = load_val;
                        model_load(load_val, c + S + 2);
                    end
                end else if (i == load_bit && j == 0) begin
                    tx_valid = 1'b1;
                    tx_data  = load_val;
                    model_load(load_val, cyc + 1);
                end
                step();
                tx_valid = 1'b0;
            end
            if (i == rst_bit) begin
                do_reset();
                live = 1'b0;
            end
        end
        cs = 1'b1;
        c  = cyc;
        if (live) begin
            bsy_c.push_back(c + S + 1);
            bsy_v.push_back(1'b0);
            if (nbits % 8 != 0) abt_c.push_back(c + S + 1);
        end
        if (!rst) cs_seen_high = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        logic [31:0] cap;
        int          lr, rv0, un0, ab0;

        do_reset();

        // Basic byte; the second load must be ignored while holding is full
        load_tx(8'hA5);
        chk(tx_ready == 1'b0, "t1_tx_ready_full", tx_ready, 0);
        load_tx(8'h77);
        rv0 = rxv_cnt;
        un0 = und_cnt;
        frame(8, 32'h3C, -1, -1, 8'h00, -1, cap, lr);
        chk(cap[7:0] == 8'hA5, "t1_miso_byte", cap[7:0], 8'hA5);
        chk(rx_data == 8'h3C, "t1_rx_data", rx_data, 8'h3C);
        chk(rxv_cnt - rv0 == 1, "t1_rx_valid_count", rxv_cnt - rv0, 1);
        chk(last_rxv_cyc - lr == 4, "t1_rx_latency", last_rxv_cyc - lr, 4);
        // Only the post-byte reload (holding empty) may flag underrun
        chk(und_cnt - un0 == 1, "t1_underrun_count", und_cnt - un0, 1);
        chk(tx_ready == 1'b1, "t1_tx_ready_empty", tx_ready, 1);

        // Back-to-back bytes with a reload mid-first-byte
        load_tx(8'h11);
        rv0 = rxv_cnt;
        un0 = und_cnt;
        frame(16, 32'hF00F, 3, -1, 8'h22, -1, cap, lr);
        chk(cap[15:0] == 16'h1122, "t2_miso_bytes", cap[15:0], 16'h1122);
        chk(rx_data == 8'h0F, "t2_rx_data", rx_data, 8'h0F);
        chk(rxv_cnt - rv0 == 2, "t2_rx_valid_count", rxv_cnt - rv0, 2);
        chk(und_cnt - un0 == 1, "t2_underrun_count", und_cnt - un0, 1);

        // Underrun from frame start
        rv0 = rxv_cnt;
        un0 = und_cnt;
        frame(8, 32'h96, -1, -1, 8'h00, -1, cap, lr);
        chk(cap[7:0] == 8'hFF, "t3_miso_fill", cap[7:0], 8'hFF);
        chk(rx_data == 8'h96, "t3_rx_data", rx_data, 8'h96);
        chk(rxv_cnt - rv0 == 1, "t3_rx_valid_count", rxv_cnt - rv0, 1);
        chk(und_cnt - un0 == 2, "t3_underrun_count", und_cnt - un0, 2);

        // Abort after 5 bits
        rv0 = rxv_cnt;
        ab0 = abt_cnt;
        frame(5, 32'h1F, -1, -1, 8'h00, -1, cap, lr);
        chk(abt_cnt - ab0 == 1, "t4_abort_count", abt_cnt - ab0, 1);
        chk(rxv_cnt - rv0 == 0, "t4_rx_valid_count", rxv_cnt - rv0, 0);
        chk(rx_data == 8'h96, "t4_rx_data_kept", rx_data, 8'h96);
        chk(miso_oe == 1'b0, "t4_miso_oe", miso_oe, 0);

        // Reset after 3 bits with cs held low; the rest of that frame is ignored
        rv0 = rxv_cnt;
        frame(11, 32'h5A5, -1, -1, 8'h00, 2, cap, lr);
        chk(rxv_cnt - rv0 == 0, "t5_no_rx_valid", rxv_cnt - rv0, 0);
        chk(rx_data == 8'h00, "t5_rx_data_reset", rx_data, 0);
        rv0 = rxv_cnt;
        frame(8, 32'h69, -1, -1, 8'h00, -1, cap, lr);
        chk(rx_data == 8'h69, "t5_rx_after_toggle", rx_data, 8'h69);
        chk(rxv_cnt - rv0 == 1, "t5_rx_valid_count", rxv_cnt - rv0, 1);

        // Load on the reload cycle of an empty holding register
        load_tx(8'h5A);
        rv0 = rxv_cnt;
        un0 = und_cnt;
        frame(24, 32'h123456, -1, 0, 8'hC3, -1, cap, lr);
        chk(cap[23:0] == 24'h5AFFC3, "t6_miso_bytes", cap[23:0], 24'h5AFFC3);
        chk(und_cnt - un0 == 2, "t6_underrun_count", und_cnt - un0, 2);
        chk(rx_data == 8'h56, "t6_rx_data", rx_data, 8'h56);
        chk(rxv_cnt - rv0 == 3, "t6_rx_valid_count", rxv_cnt - rv0, 3);

        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
